bin_to_bcd_conv: RTL and testbench

Parametrised iterative double-dabble converter. It turns a BIN_W-bit binary word into DIGITS packed BCD digits and reports the number of significant digits and any overflow. It replaces the fixed 32-bit trigger/idle converter and uses valid/ready handshakes on both sides. It sits between arithmetic/counter logic and the 7-segment display drivers.

---
 rtl/bin_to_bcd_conv.sv | 128 ++++++++++++
 tb/tb_bin_to_bcd_conv.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_conv.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready handshakes on both sides.
// Optional two's-complement input support is enabled by defining BCD_SIGNED_EN.
module bin_to_bcd_conv #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*DIGITS-1:0]           bcd,
    output logic [$clog2(DIGITS+1)-1:0]   ndigits,
    output logic                          overflow,
`ifdef BCD_SIGNED_EN
    input  logic                          is_signed,
    output logic                          neg,
`endif
    output logic [2:0]                    state
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int NDW   = $clog2(DIGITS + 1);

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_CONV = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    // out_valid holds with stable data until accepted; in_ready is high only in S_IDLE.

    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    bin_q;
    logic [4*DIGITS-1:0] scratch;
    logic                ovf_q;
    logic [4*DIGITS-1:0] corr;
    logic [4*DIGITS-1:0] scr_next;
    logic                ovf_next;
    logic [NDW-1:0]      nd_next;
`ifdef BCD_SIGNED_EN
    logic                neg_q;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // One double-dabble step: per-digit +3 (no inter-digit carry), then shift in the next bit.
    always_comb begin
        corr = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                corr[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scr_next = {corr[4*DIGITS-2:0], bin_q[BIN_W-1]};
        ovf_next = ovf_q | corr[4*DIGITS-1];
        nd_next  = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_next[4*i +: 4] != 4'd0)
                nd_next = NDW'(i + 1);
        end
        if (ovf_next)
            nd_next = NDW'(DIGITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bin_q    <= '0;
            scratch  <= '0;
            ovf_q    <= 1'b0;
            bcd      <= '0;
            ndigits  <= NDW'(1);
            overflow <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg_q    <= 1'b0;
            neg      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef BCD_SIGNED_EN
                        // Unsigned negation so the most negative value maps to 2^(BIN_W-1).
                        if (is_signed && in_data[BIN_W-1]) begin
                            bin_q <= (~in_data) + BIN_W'(1);
                            neg_q <= 1'b1;
                        end else begin
                            bin_q <= in_data;
                            neg_q <= 1'b0;
                        end
`else
                        bin_q <= in_data;
`endif
                        scratch <= '0;
                        ovf_q   <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    bin_q   <= bin_q << 1;
                    scratch <= scr_next;
                    ovf_q   <= ovf_next;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd      <= scr_next;
                        ndigits  <= nd_next;
                        overflow <= ovf_next;
`ifdef BCD_SIGNED_EN
                        neg      <= neg_q;
`endif
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Directed bench for bin_to_bcd_conv: a 32-bit/10-digit instance and a 16-bit/3-digit instance.
module tb_bin_to_bcd_conv;

    localparam logic [2:0] S_IDLE = 3'b001;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [39:0] a_bcd;
    logic [3:0]  a_ndigits;
    logic        a_overflow;
    logic [2:0]  a_state;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [11:0] b_bcd;
    logic [1:0]  b_ndigits;
    logic        b_overflow;
    logic [2:0]  b_state;

`ifdef BCD_SIGNED_EN
    logic a_is_signed = 1'b0;
    logic a_neg;
    logic b_is_signed = 1'b0;
    logic b_neg;
`endif

    always #5 clk = ~clk;

    bin_to_bcd_conv #(.BIN_W(32), .DIGITS(10)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd(a_bcd), .ndigits(a_ndigits), .overflow(a_overflow),
`ifdef BCD_SIGNED_EN
        .is_signed(a_is_signed), .neg(a_neg),
`endif
        .state(a_state)
    );

    bin_to_bcd_conv #(.BIN_W(16), .DIGITS(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .bcd(b_bcd), .ndigits(b_ndigits), .overflow(b_overflow),
`ifdef BCD_SIGNED_EN
        .is_signed(b_is_signed), .neg(b_neg),
`endif
        .state(b_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word to instance A, then count edges until out_valid (bounded).
    task automatic run_a(input logic [31:0] d, input logic sgn, output int lat);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = d;
`ifdef BCD_SIGNED_EN
        a_is_signed = sgn;
`else
        if (sgn) $display("[TB] signed request ignored in unsigned build");
`endif
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = $urandom;
        lat = 0;
        while (!a_out_valid && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_b(input logic [15:0] d, output int lat);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = 16'($urandom);
        lat = 0;
        while (!b_out_valid && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop_a();
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
    endtask

    task automatic pop_b();
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
    endtask

    initial begin
        int lat;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_bcd", 64'(a_bcd), 64'd0);
        chk("rst_ndigits", 64'(a_ndigits), 64'd1);
        chk("rst_overflow", 64'(a_overflow), 64'd0);
        chk("rst_state", 64'(a_state), 64'(S_IDLE));
        rst_n = 1'b1;

        // Zero
        run_a(32'd0, 1'b0, lat);
        chk("zero_latency", 64'(lat), 64'd32);
        chk("zero_bcd", 64'(a_bcd), 64'h0);
        chk("zero_ndigits", 64'(a_ndigits), 64'd1);
        chk("zero_overflow", 64'(a_overflow), 64'd0);
        pop_a();

        // All ones
        run_a(32'hFFFF_FFFF, 1'b0, lat);
        chk("max_latency", 64'(lat), 64'd32);
        chk("max_bcd", 64'(a_bcd), 64'h42_9496_7295);
        chk("max_ndigits", 64'(a_ndigits), 64'd10);
        chk("max_overflow", 64'(a_overflow), 64'd0);
        pop_a();
        chk("max_back_idle", 64'(a_state), 64'(S_IDLE));

        run_a(32'd1000000, 1'b0, lat);
        chk("mil_bcd", 64'(a_bcd), 64'h100_0000);
        chk("mil_ndigits", 64'(a_ndigits), 64'd7);
        pop_a();

        // Narrow instance: overflow and exact fit
        run_b(16'd1234, lat);
        chk("b1234_latency", 64'(lat), 64'd16);
        chk("b1234_bcd", 64'(b_bcd), 64'h234);
        chk("b1234_ndigits", 64'(b_ndigits), 64'd3);
        chk("b1234_overflow", 64'(b_overflow), 64'd1);
        pop_b();
        run_b(16'd999, lat);
        chk("b999_bcd", 64'(b_bcd), 64'h999);
        chk("b999_ndigits", 64'(b_ndigits), 64'd3);
        chk("b999_overflow", 64'(b_overflow), 64'd0);
        pop_b();
        run_b(16'd1000, lat);
        chk("b1000_bcd", 64'(b_bcd), 64'h000);
        chk("b1000_overflow", 64'(b_overflow), 64'd1);
        pop_b();

        // Back-pressure with a competing input word
        run_a(32'd7, 1'b0, lat);
        chk("bp_bcd", 64'(a_bcd), 64'h7);
        chk("bp_ndigits", 64'(a_ndigits), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_data  = 32'd123;
            chk("bp_out_valid", 64'(a_out_valid), 64'd1);
            chk("bp_bcd_hold", 64'(a_bcd), 64'h7);
            chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        end
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        chk("bp_idle_state", 64'(a_state), 64'(S_IDLE));
        chk("bp_idle_in_ready", 64'(a_in_ready), 64'd1);
        chk("bp_idle_out_valid", 64'(a_out_valid), 64'd0);

        // Reset in the middle of a conversion
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = 32'd99999;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("mid_rst_bcd", 64'(a_bcd), 64'd0);
        chk("mid_rst_ndigits", 64'(a_ndigits), 64'd1);
        chk("mid_rst_overflow", 64'(a_overflow), 64'd0);
        chk("mid_rst_state", 64'(a_state), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        run_a(32'd42, 1'b0, lat);
        chk("post_rst_latency", 64'(lat), 64'd32);
        chk("post_rst_bcd", 64'(a_bcd), 64'h42);
        chk("post_rst_ndigits", 64'(a_ndigits), 64'd2);
        pop_a();

`ifdef BCD_SIGNED_EN
        run_a(32'hFFFF_FFFF, 1'b1, lat);
        chk("s_m1_bcd", 64'(a_bcd), 64'h1);
        chk("s_m1_neg", 64'(a_neg), 64'd1);
        chk("s_m1_latency", 64'(lat), 64'd32);
        pop_a();
        run_a(32'h8000_0000, 1'b1, lat);
        chk("s_min_bcd", 64'(a_bcd), 64'h21_4748_3648);
        chk("s_min_neg", 64'(a_neg), 64'd1);
        pop_a();
        run_a(32'h8000_0000, 1'b0, lat);
        chk("u_min_bcd", 64'(a_bcd), 64'h21_4748_3648);
        chk("u_min_neg", 64'(a_neg), 64'd0);
        pop_a();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
